// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the N-master bus arbiter.
package bus_arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_OWNED = 1'b1
  } arb_state_e;

  localparam int unsigned ARB_FIXED       = 0;
  localparam int unsigned ARB_RR          = 1;
  localparam int unsigned ARB_MAX_MASTERS = 16;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner search: first eligible requester at or after start_i, wrapping.
module arb_pick #(
  parameter int unsigned NUM_MASTERS = 4,
  parameter int unsigned ID_W        = 2
) (
  input  logic [NUM_MASTERS-1:0] req_i,
  input  logic [ID_W-1:0]        start_i,
  input  logic [NUM_MASTERS-1:0] excl_i,
  output logic [NUM_MASTERS-1:0] gnt_o,
  output logic [ID_W-1:0]        idx_o,
  output logic                   found_o
);

  logic [NUM_MASTERS-1:0] cand;

  assign cand = req_i & ~excl_i;

  always_comb begin
    int unsigned j;
    gnt_o   = '0;
    idx_o   = '0;
    found_o = 1'b0;
    j       = 0;
    for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
      j = (32'(start_i) + k) % NUM_MASTERS;
      if (!found_o && cand[j]) begin
        found_o  = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_n.sv
// N-master bus arbiter: fixed-priority or round-robin, bounded tenure, per-master lock.
module bus_arbiter_n
  import bus_arb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 4,
  parameter int unsigned RR_MODE     = ARB_FIXED,
  parameter int unsigned MAX_HOLD    = 16,
  parameter int unsigned ID_W        = (NUM_MASTERS > 2) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_MASTERS-1:0] MASTER_READ,
  input  logic [NUM_MASTERS-1:0] MASTER_WRITE,
  input  logic [NUM_MASTERS-1:0] MASTER_LOCK,
  output logic [NUM_MASTERS-1:0] GRANT,
  output logic [ID_W-1:0]        grant_id,
  output logic                   grant_valid,
  output logic                   hold_timeout
);

  localparam int unsigned     HOLD_W   = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [ID_W-1:0] LAST_IDX = ID_W'(NUM_MASTERS - 1);

  arb_state_e        state_q, state_d;
  logic [ID_W-1:0]   owner_q, owner_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              timeout_q, timeout_d;

  logic [NUM_MASTERS-1:0] req, owner_oh, excl, pick_gnt;
  logic [ID_W-1:0]        start, pick_idx;
  logic                   pick_found, owner_req, owner_lock, others_req;
  logic                   hold_due, timeout_fire, new_grant;

  assign req        = MASTER_READ | MASTER_WRITE;
  assign owner_oh   = NUM_MASTERS'(1) << owner_q;
  assign owner_req  = req[owner_q];
  assign owner_lock = MASTER_LOCK[owner_q];
  assign others_req = |(req & ~owner_oh);

  // Due from the last cycle before the limit onward, so a lock release on a saturated
  // counter still revokes the tenure.
  assign hold_due     = (MAX_HOLD != 0) && ((32'(hold_q) + 32'd1) >= MAX_HOLD);
  assign timeout_fire = (state_q == ARB_OWNED) && owner_req && !owner_lock && others_req &&
                        hold_due;

  assign excl  = timeout_fire ? owner_oh : '0;
  assign start = (RR_MODE == ARB_RR) ? ((rr_ptr_q == LAST_IDX) ? '0 : rr_ptr_q + 1'b1) : '0;

  arb_pick #(
    .NUM_MASTERS(NUM_MASTERS),
    .ID_W       (ID_W)
  ) u_pick (
    .req_i  (req),
    .start_i(start),
    .excl_i (excl),
    .gnt_o  (pick_gnt),
    .idx_o  (pick_idx),
    .found_o(pick_found)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ARB_IDLE;
      owner_q   <= '0;
      rr_ptr_q  <= LAST_IDX;
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_ptr_q  <= rr_ptr_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_ptr_d  = rr_ptr_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    new_grant = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        new_grant = pick_found;
      end
      ARB_OWNED: begin
        if (!owner_req || timeout_fire) begin
          new_grant = pick_found;
          timeout_d = timeout_fire;
          if (!pick_found) begin
            state_d = ARB_IDLE;
            owner_d = '0;
            hold_d  = '0;
          end
        // One-hot vectors order like their indices: a smaller pick is a higher priority.
        end else if ((RR_MODE == ARB_FIXED) && !owner_lock && (pick_gnt < owner_oh)) begin
          new_grant = 1'b1;
        end else if (hold_q != HOLD_W'(MAX_HOLD)) begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: ;
    endcase
    if (new_grant) begin
      state_d  = ARB_OWNED;
      owner_d  = pick_idx;
      rr_ptr_d = pick_idx;
      hold_d   = '0;
    end
  end

  always_comb begin
    GRANT       = '0;
    grant_id    = '0;
    grant_valid = 1'b0;
    if (state_q == ARB_OWNED) begin
      GRANT       = owner_oh;
      grant_id    = owner_q;
      grant_valid = 1'b1;
    end
  end

  assign hold_timeout = timeout_q;

endmodule

// File: doc/bus_arbiter_n.md
Name: bus_arbiter_n

Overview:
- Parametrised N-master arbiter for the internal MCU bus. Successor to the two-master fixed-priority arbiter.
- Adds a selectable fixed-priority or round-robin policy, a bounded grant tenure (hold timeout), and per-master bus lock.
- Sits between bus masters (CPU, DMA, debug, comm peripherals) and the internal bus mux. Its registered one-hot grant drives the address/data mux selects directly.

Parameters:
- NUM_MASTERS, 4, number of requesting masters (2..16); master 0 has highest fixed priority.
- RR_MODE, 0, 0 = fixed priority with preemption; 1 = round-robin, no preemption.
- MAX_HOLD, 16, tenure limit in cycles before forced re-arbitration when others wait; 0 disables the limit.
- ID_W, $clog2(NUM_MASTERS) (min 1), width of grant_id.

Ports:
- clk  input  1  bus clock, all state on rising edge
- rst  input  1  asynchronous active-low reset (asserted when 0), synchronous deassertion expected from the reset block
- MASTER_READ  input  NUM_MASTERS  per-master read request
- MASTER_WRITE  input  NUM_MASTERS  per-master write request
- MASTER_LOCK  input  NUM_MASTERS  owner requests an atomic sequence; blocks preemption and timeout
- GRANT  output  NUM_MASTERS  registered one-hot grant, all-zero when idle
- grant_id  output  ID_W  binary index of owner, 0 when idle
- grant_valid  output  1  OR of GRANT
- hold_timeout  output  1  one-cycle pulse in the cycle a tenure is revoked by MAX_HOLD

Behaviour:
- Request: req[i] = MASTER_READ[i] | MASTER_WRITE[i]. Lock is meaningful only while req[i] is high.
- Reset (rst=0, async): GRANT=0, grant_id=0, grant_valid=0, hold_timeout=0, FSM=IDLE, hold counter=0, RR pointer=NUM_MASTERS-1 (so master 0 is searched first).
- FSM states: IDLE, OWNED. The owner index is held in a register.
- IDLE: no req -> stay. Any req -> OWNED with winner W, GRANT[W]=1 on the next edge (1-cycle latency, registered).
- Winner, fixed mode: lowest-index requester.
- Winner, RR mode: first requester searched from (rr_ptr+1) mod NUM_MASTERS upward, wrapping. rr_ptr <= W on every new grant.
- OWNED, owner drops req -> re-arbitrate in the same cycle. Another requester -> direct handover next edge, no idle bubble. None -> IDLE next edge.
- OWNED, fixed mode, no lock: a requester with index < owner preempts. GRANT switches to it next edge.
- OWNED, RR mode: no preemption while owner requests, except via timeout.
- Hold counter: clears on every new grant; increments each OWNED cycle; saturates at MAX_HOLD.
- Timeout fires when all hold: MAX_HOLD!=0, counter==MAX_HOLD-1, owner still requesting, owner lock low, at least one other requester. Effect: re-arbitrate excluding the owner, hand over next edge, pulse hold_timeout coincident with the new GRANT.
- Timeout with no other requester: does not fire; owner keeps the grant and the counter saturates.
- Lock high: suppresses preemption and timeout. Timeout fires on the first cycle lock falls if counter is saturated and others wait.
- Simultaneous owner-drop and higher-priority request: normal re-arbitration; no timeout pulse.
- Invariants: GRANT always one-hot or zero; grant_id/grant_valid consistent with GRANT in the same cycle (all registered together).
- Reset mid-tenure: grant removed asynchronously; after release, arbitration restarts from IDLE and the RR pointer is reinitialised.

Decomposition:
- Shared package bus_arb_pkg: FSM state enum (ARB_IDLE, ARB_OWNED), mode constants ARB_FIXED=0 / ARB_RR=1, NUM_MASTERS upper bound.
- One sub-module: arb_pick. Purely combinational: request vector + start index + exclude mask -> winner one-hot + index + found. Instantiated once. Fixed mode passes start=0 with no rotation.
- The top holds the FSM, owner register, hold counter and RR pointer.

Test Plan:
- Reset/idle, N=4 fixed: rst=0 with requests active -> GRANT=0000, grant_id=0. Release with MASTER_READ=0100 -> GRANT=0100, grant_id=2 one edge later.
- Fixed preemption: master 2 owns, MASTER_WRITE[0] rises -> next edge GRANT=0001. Repeat with MASTER_LOCK[2]=1 -> GRANT stays 0100 until lock falls.
- Round-robin, RR_MODE=1, all four requesting and each dropping after 1 cycle of grant -> grant order 0,1,2,3,0; no preemption observed.
- Hold timeout, MAX_HOLD=4, RR_MODE=1: master 1 holds, master 3 requests -> after 4 OWNED cycles GRANT=1000 with hold_timeout=1 for exactly one cycle. With master 3 idle -> master 1 keeps the grant indefinitely.
- Back-to-back handover: owner 0 drops while 1 requests -> GRANT 0001->0010 on consecutive edges, grant_valid never 0.
- Async reset mid-tenure: rst=0 between edges while GRANT=0010 -> GRANT=0 immediately. After release with master 3 requesting, RR pointer=3 so search starts at 0 -> GRANT=1000 next edge.
